// File: rtl/bsg_mesh_router_pkg.sv
// bsg_mesh_router_pkg
//   Shared definitions for the 5-port dimension-ordered mesh router slice.
//   - dir_e          : port/direction encoding (P=0, W=1, E=2, N=3, S=4)
//   - dirs_default_p : default number of router ports
//   - req_idx()      : flat index of the (input, output) pair in the
//                      request/grant matrices (input-major, i*dirs+j)

package bsg_mesh_router_pkg;

  localparam int dirs_default_p = 5;

  typedef enum logic [2:0] {
    DIR_P = 3'd0,
    DIR_W = 3'd1,
    DIR_E = 3'd2,
    DIR_N = 3'd3,
    DIR_S = 3'd4
  } dir_e;

  // Bit position of "input in_dir wants output out_dir" in req/grant vectors.
  function automatic int req_idx(input int in_dir, input int out_dir, input int dirs);
    return in_dir * dirs + out_dir;
  endfunction

endpackage

// File: rtl/bsg_mesh_router_rr_arb.sv
// bsg_mesh_router_rr_arb
//   Round-robin arbiter for a single router output. Picks one requesting
//   input starting the scan at the rotating pointer. Optional wormhole
//   locking keeps the output on one input until that input's tail flit
//   has been transferred.
//
//   Build option: BSG_MESH_ROUTER_ALLOC_LOCK_EN enables the lock register.
//   Without it tail_i is ignored and arbitration is per flit.
//
// Ports:
//   clk_i    : clock
//   reset_i  : asynchronous active-high reset
//   req_i    : per-input request for this output (already one-hot per input)
//   tail_i   : per-input "head flit is the last of its packet"
//   ready_i  : downstream of this output accepts a flit this cycle
//   grant_o  : one-hot (or zero) grant, forced to 0 during reset

module bsg_mesh_router_rr_arb
  import bsg_mesh_router_pkg::*;
#(
  parameter int dirs_p = dirs_default_p
)
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [dirs_p-1:0] req_i,
  input  logic [dirs_p-1:0] tail_i,
  input  logic              ready_i,
  output logic [dirs_p-1:0] grant_o
);

  localparam int ptr_w_lp = (dirs_p > 1) ? $clog2(dirs_p) : 1;
  localparam logic [ptr_w_lp:0]   dirs_lp    = (ptr_w_lp+1)'(dirs_p);
  localparam logic [ptr_w_lp-1:0] last_id_lp = ptr_w_lp'(dirs_p - 1);
  localparam logic [ptr_w_lp-1:0] one_lp     = ptr_w_lp'(1);

  logic [ptr_w_lp-1:0] ptr_r;
  logic [ptr_w_lp-1:0] ptr_n;
  logic [ptr_w_lp-1:0] win_id;
  logic [dirs_p-1:0]   rr_grant;
  logic [dirs_p-1:0]   grant;
  logic                xfer;

  // Rotating priority scan: position o of the scan looks at input
  // (ptr_r + o) mod dirs_p; the first requester found wins.
  always_comb begin
    logic [ptr_w_lp:0] pos;
    logic              found;
    rr_grant = '0;
    found    = 1'b0;
    pos      = '0;
    for (int o = 0; o < dirs_p; o++) begin
      pos = {1'b0, ptr_r} + (ptr_w_lp+1)'(o);
      if (pos >= dirs_lp) pos = pos - dirs_lp;
      if (!found && req_i[pos[ptr_w_lp-1:0]]) begin
        rr_grant[pos[ptr_w_lp-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

  // Encode the winning input and the pointer value that follows it.
  always_comb begin
    win_id = '0;
    for (int k = 0; k < dirs_p; k++) begin
      if (grant[k]) win_id = ptr_w_lp'(k);
    end
    ptr_n = (win_id == last_id_lp) ? '0 : win_id + one_lp;
  end

  assign xfer = ready_i & (|grant);

`ifdef BSG_MESH_ROUTER_ALLOC_LOCK_EN

  logic                lock_v_r;
  logic [ptr_w_lp-1:0] lock_id_r;

  // A locked output serves only the owning input, and only while that
  // input is actually requesting this output.
  always_comb begin
    grant = rr_grant;
    if (lock_v_r) begin
      grant            = '0;
      grant[lock_id_r] = req_i[lock_id_r];
    end
    if (reset_i) grant = '0;
  end

  // Body flits take/keep the lock; the tail releases it and only then
  // rotates priority past the owner.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_r     <= '0;
      lock_v_r  <= 1'b0;
      lock_id_r <= '0;
    end else if (xfer) begin
      if (tail_i[win_id]) begin
        lock_v_r <= 1'b0;
        ptr_r    <= ptr_n;
      end else begin
        lock_v_r  <= 1'b1;
        lock_id_r <= win_id;
      end
    end
  end

`else

  logic unused_tail;
  assign unused_tail = ^tail_i;

  always_comb begin
    grant = reset_i ? '0 : rr_grant;
  end

  // Every accepted flit rotates priority past its sender.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_r <= '0;
    end else if (xfer) begin
      ptr_r <= ptr_n;
    end
  end

`endif

  assign grant_o = grant;

endmodule

// File: rtl/bsg_mesh_router_output_alloc.sv
// bsg_mesh_router_output_alloc
//   Switch allocator for the 5-port DOR mesh router. Takes the decoder's
//   request matrix and produces at most one grant per output and per input,
//   using one round-robin arbiter per output.
//
//   Build option: BSG_MESH_ROUTER_ALLOC_LOCK_EN turns on wormhole locking
//   inside each output arbiter.
//
// Ports:
//   clk_i       : clock
//   reset_i     : asynchronous active-high reset
//   req_i       : request matrix, bit i*dirs_p+j = input i wants output j
//   tail_i      : per-input tail flag of the current head flit
//   out_ready_i : per-output downstream ready
//   grant_o     : grant matrix, same indexing as req_i
//   out_v_o     : per-output valid (some input granted)
//   yumi_o      : per-input dequeue (granted and downstream ready)
//   err_o       : sticky flag, an input requested more than one output

module bsg_mesh_router_output_alloc
  import bsg_mesh_router_pkg::*;
#(
  parameter int dirs_p = dirs_default_p
)
(
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [dirs_p*dirs_p-1:0] req_i,
  input  logic [dirs_p-1:0]        tail_i,
  input  logic [dirs_p-1:0]        out_ready_i,
  output logic [dirs_p*dirs_p-1:0] grant_o,
  output logic [dirs_p-1:0]        out_v_o,
  output logic [dirs_p-1:0]        yumi_o,
  output logic                     err_o
);

  // Cleaned request matrix: U-turns removed and at most one bit per input.
  logic [dirs_p*dirs_p-1:0] sel_req;
  logic [dirs_p-1:0]        multi_req;
  logic                     err_r;

  // Input side: drop U-turns (P->P is a legal local loopback), then keep
  // only the lowest-index output so each input competes for one output.
  for (genvar i = 0; i < dirs_p; i++) begin : g_in
    logic [dirs_p-1:0] row;
    logic [dirs_p-1:0] below;

    for (genvar j = 0; j < dirs_p; j++) begin : g_bit
      if (i != 0 && i == j) begin : g_uturn
        assign row[j] = 1'b0;
      end else begin : g_legal
        assign row[j] = req_i[req_idx(i, j, dirs_p)];
      end

      if (j == 0) begin : g_first
        assign below[j] = 1'b0;
      end else begin : g_rest
        assign below[j] = |row[j-1:0];
      end

      assign sel_req[req_idx(i, j, dirs_p)] = row[j] & ~below[j];
    end

    assign multi_req[i] = |(row & below);
  end

  // Output side: one arbiter per output, fed with that output's column.
  for (genvar j = 0; j < dirs_p; j++) begin : g_out
    logic [dirs_p-1:0] col_req;
    logic [dirs_p-1:0] col_grant;

    for (genvar i = 0; i < dirs_p; i++) begin : g_col
      assign col_req[i]                     = sel_req[req_idx(i, j, dirs_p)];
      assign grant_o[req_idx(i, j, dirs_p)] = col_grant[i];
    end

    bsg_mesh_router_rr_arb #(
      .dirs_p (dirs_p)
    ) arb (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .req_i   (col_req),
      .tail_i  (tail_i),
      .ready_i (out_ready_i[j]),
      .grant_o (col_grant)
    );

    assign out_v_o[j] = |col_grant;
  end

  // An input dequeues when its single granted output is ready.
  for (genvar i = 0; i < dirs_p; i++) begin : g_yumi
    assign yumi_o[i] = |(grant_o[i*dirs_p +: dirs_p] & out_ready_i);
  end

  // Sticky error for malformed decoder output; only reset clears it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_r <= 1'b0;
    end else if (|multi_req) begin
      err_r <= 1'b1;
    end
  end

  assign err_o = err_r;

endmodule

// File: tb/tb_bsg_mesh_router_output_alloc.sv
// tb_bsg_mesh_router_output_alloc
//   Bench for the mesh router output allocator. A rule-level model (which
//   output each input really asks for, who wins each output from its
//   rotating start position, lock ownership) predicts every output; a
//   negedge process compares against it each cycle, and directed steps pin
//   hand-computed values. Honors BSG_MESH_ROUTER_ALLOC_LOCK_EN.

module tb_bsg_mesh_router_output_alloc;

  localparam int n = 5;

  logic           clk_i = 1'b0;
  logic           reset_i = 1'b0;
  logic [n*n-1:0] req_i = '0;
  logic [n-1:0]   tail_i = '1;
  logic [n-1:0]   out_ready_i = '1;
  logic [n*n-1:0] grant_o;
  logic [n-1:0]   out_v_o;
  logic [n-1:0]   yumi_o;
  logic           err_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state
  int m_ptr[n];
  bit m_lock_v[n];
  int m_lock_id[n];
  bit m_err;

  // Model predictions for the current cycle
  int             eff[n];
  int             exp_win[n];
  logic [n*n-1:0] exp_grant;
  logic [n-1:0]   exp_out_v;
  logic [n-1:0]   exp_yumi;
  bit             exp_multi;

  logic [n-1:0] rot_exp[4];
  logic [n-1:0] worm_exp[4];

  bsg_mesh_router_output_alloc #(
    .dirs_p (n)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .tail_i      (tail_i),
    .out_ready_i (out_ready_i),
    .grant_o     (grant_o),
    .out_v_o     (out_v_o),
    .yumi_o      (yumi_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [n*n-1:0] r, input logic [n-1:0] t,
                               input logic [n-1:0] rdy);
    @(posedge clk_i);
    #1;
    req_i       = r;
    tail_i      = t;
    out_ready_i = rdy;
  endtask

  // Rule model: each input asks for its lowest legal output; each output is
  // won by its lock owner, or else by the first asking input counting up
  // from its pointer.
  always_comb begin
    exp_grant = '0;
    exp_out_v = '0;
    exp_yumi  = '0;
    exp_multi = 1'b0;
    for (int i = 0; i < n; i++) begin
      eff[i] = -1;
      for (int j = 0; j < n; j++) begin
        if (req_i[i*n+j] && !(i > 0 && i == j)) begin
          if (eff[i] < 0) eff[i] = j;
          else exp_multi = 1'b1;
        end
      end
    end
    for (int j = 0; j < n; j++) begin
      exp_win[j] = -1;
      if (m_lock_v[j]) begin
        if (eff[m_lock_id[j]] == j) exp_win[j] = m_lock_id[j];
      end else begin
        for (int o = 0; o < n; o++) begin
          int k;
          k = (m_ptr[j] + o) % n;
          if (exp_win[j] < 0 && eff[k] == j) exp_win[j] = k;
        end
      end
      if (exp_win[j] >= 0 && !reset_i) begin
        exp_grant[exp_win[j]*n+j] = 1'b1;
        exp_out_v[j] = 1'b1;
        if (out_ready_i[j]) exp_yumi[exp_win[j]] = 1'b1;
      end
    end
  end

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int j = 0; j < n; j++) begin
        m_ptr[j]     <= 0;
        m_lock_v[j]  <= 1'b0;
        m_lock_id[j] <= 0;
      end
      m_err <= 1'b0;
    end else begin
      if (exp_multi) m_err <= 1'b1;
      for (int j = 0; j < n; j++) begin
        if (exp_win[j] >= 0 && out_ready_i[j]) begin
`ifdef BSG_MESH_ROUTER_ALLOC_LOCK_EN
          if (tail_i[exp_win[j]]) begin
            m_lock_v[j] <= 1'b0;
            m_ptr[j]    <= (exp_win[j] + 1) % n;
          end else begin
            m_lock_v[j]  <= 1'b1;
            m_lock_id[j] <= exp_win[j];
          end
`else
          m_ptr[j] <= (exp_win[j] + 1) % n;
`endif
        end
      end
    end
  end

  always @(negedge clk_i) begin
    checkOutput("cyc_grant", 32'(grant_o), 32'(exp_grant));
    checkOutput("cyc_out_v", 32'(out_v_o), 32'(exp_out_v));
    checkOutput("cyc_yumi", 32'(yumi_o), 32'(exp_yumi));
    checkOutput("cyc_err", 32'(err_o), 32'(m_err));
  end

  initial begin
    rot_exp[0] = 5'b00010;
    rot_exp[1] = 5'b01000;
    rot_exp[2] = 5'b10000;
    rot_exp[3] = 5'b00010;
`ifdef BSG_MESH_ROUTER_ALLOC_LOCK_EN
    worm_exp[0] = 5'b00010;
    worm_exp[1] = 5'b00010;
    worm_exp[2] = 5'b00010;
    worm_exp[3] = 5'b01000;
`else
    worm_exp[0] = 5'b00010;
    worm_exp[1] = 5'b01000;
    worm_exp[2] = 5'b00010;
    worm_exp[3] = 5'b01000;
`endif

    // Reset with every request bit set: outputs must stay quiet.
    req_i = '1;
    #1 reset_i = 1'b1;
    @(negedge clk_i);
    checkOutput("rst_grant", 32'(grant_o), 32'h0);
    checkOutput("rst_out_v", 32'(out_v_o), 32'h0);
    checkOutput("rst_yumi", 32'(yumi_o), 32'h0);
    checkOutput("rst_err", 32'(err_o), 32'h0);

    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    req_i   = '0;
    @(negedge clk_i);
    checkOutput("idle_grant", 32'(grant_o), 32'h0);
    checkOutput("idle_err", 32'(err_o), 32'h0);

    // W, N, S contend for E.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(25'h420080, 5'b11111, 5'b11111);
      @(negedge clk_i);
      checkOutput($sformatf("rot_yumi%0d", c), 32'(yumi_o), 32'(rot_exp[c]));
    end

    // P to E with E stalled for three cycles.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(25'h4, 5'b11111, (c < 3) ? 5'b11011 : 5'b11111);
      @(negedge clk_i);
      checkOutput($sformatf("bp_grant%0d", c), 32'(grant_o), 32'h4);
      checkOutput($sformatf("bp_yumi%0d", c), 32'(yumi_o), (c < 3) ? 32'h0 : 32'h1);
    end
    // E pointer now 1: among P, W, N the W input wins.
    applyStimulus(25'h20084, 5'b11111, 5'b11111);
    @(negedge clk_i);
    checkOutput("bp_ptr_yumi", 32'(yumi_o), 32'h2);
    applyStimulus(25'h4, 5'b11111, 5'b11111);
    @(negedge clk_i);
    checkOutput("bp_ptr1_yumi", 32'(yumi_o), 32'h1);

    // W sends a 3-flit packet to E while N also wants E.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(25'h20080, (c < 2) ? 5'b11101 : 5'b11111, 5'b11111);
      @(negedge clk_i);
      checkOutput($sformatf("worm_yumi%0d", c), 32'(yumi_o), 32'(worm_exp[c]));
    end

    // P->P loopback is legal.
    applyStimulus(25'h1, 5'b11111, 5'b11111);
    @(negedge clk_i);
    checkOutput("pp_grant", 32'(grant_o), 32'h1);
    checkOutput("pp_out_v", 32'(out_v_o), 32'h1);

    // W->W U-turn alone: ignored, not an error.
    applyStimulus(25'h40, 5'b11111, 5'b11111);
    @(negedge clk_i);
    checkOutput("uturn_grant", 32'(grant_o), 32'h0);
    checkOutput("uturn_err", 32'(err_o), 32'h0);

    // E asks for E (masked) and N: only N remains, still not an error.
    applyStimulus(25'h3000, 5'b11111, 5'b11111);
    @(negedge clk_i);
    checkOutput("uturn_mix_grant", 32'(grant_o), 32'h2000);

    // E asks for P and N: lowest output wins, error raised next edge.
    applyStimulus(25'h2400, 5'b11111, 5'b11111);
    @(negedge clk_i);
    checkOutput("multi_grant", 32'(grant_o), 32'h400);
    checkOutput("multi_yumi", 32'(yumi_o), 32'h4);
    checkOutput("multi_err_pre", 32'(err_o), 32'h0);
    applyStimulus(25'h0, 5'b11111, 5'b11111);
    @(negedge clk_i);
    checkOutput("multi_err_set", 32'(err_o), 32'h1);
    applyStimulus(25'h0, 5'b11111, 5'b11111);
    @(negedge clk_i);
    checkOutput("multi_err_hold", 32'(err_o), 32'h1);

    // W takes S with a body flit, then reset lands mid-cycle.
    applyStimulus(25'h200, 5'b00000, 5'b11111);
    @(negedge clk_i);
    checkOutput("mid_grant", 32'(grant_o), 32'h200);
    @(posedge clk_i);
    #1 req_i = 25'h80200;
    #1 reset_i = 1'b1;
    #1;
    checkOutput("mid_rst_grant", 32'(grant_o), 32'h0);
    checkOutput("mid_rst_out_v", 32'(out_v_o), 32'h0);
    checkOutput("mid_rst_yumi", 32'(yumi_o), 32'h0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    req_i   = 25'h80000;
    tail_i  = 5'b11111;
    @(negedge clk_i);
    checkOutput("post_rst_grant", 32'(grant_o), 32'h80000);
    checkOutput("post_rst_yumi", 32'(yumi_o), 32'h8);
    checkOutput("post_rst_err", 32'(err_o), 32'h0);

    applyStimulus(25'h0, 5'b11111, 5'b11111);
    @(negedge clk_i);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
